// File: rtl/debug_master_wb.sv
// Wishbone B4 pipelined initiator for bench/debug agents: one command in flight,
// and every accepted command ends in exactly one response (ack, err or timeout).
module debug_master_wb #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [ADDR_W-1:0]   req_adr,
  input  logic [DATA_W-1:0]   req_dat,
  input  logic [DATA_W/8-1:0] req_sel,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_dat,
  output logic                rsp_err,
  output logic                rsp_timeout,
  output logic                wb_cyc_o,
  output logic                wb_stb_o,
  output logic                wb_we_o,
  output logic [ADDR_W-1:0]   wb_adr_o,
  output logic [DATA_W-1:0]   wb_dat_o,
  output logic [DATA_W/8-1:0] wb_sel_o,
  input  logic                wb_stall_i,
  input  logic                wb_ack_i,
  input  logic [DATA_W-1:0]   wb_dat_i,
  input  logic                wb_err_i
);

  localparam int SEL_W = DATA_W / 8;
  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam bit TMO_EN = (TIMEOUT_CYCLES > 0);
  // The counter value seen on the edge that completes TIMEOUT_CYCLES cycles of cyc.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_RESP
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ready_d;
  logic               cyc_d, stb_d, we_d;
  logic [ADDR_W-1:0]  adr_d;
  logic [DATA_W-1:0]  dat_d;
  logic [SEL_W-1:0]   sel_d;
  logic               rsp_valid_d, rsp_err_d, rsp_timeout_d;
  logic [DATA_W-1:0]  rsp_dat_d;

  logic strobe_taken;
  logic bus_done;
  logic timeout_hit;

  assign strobe_taken = (state_q == S_REQ) && !wb_stall_i;
  assign bus_done     = ((state_q == S_WAIT) || strobe_taken) && (wb_ack_i || wb_err_i);
  assign timeout_hit  = TMO_EN && (cnt_q == CNT_LAST);

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    ready_d       = 1'b0;
    cyc_d         = wb_cyc_o;
    stb_d         = wb_stb_o;
    we_d          = wb_we_o;
    adr_d         = wb_adr_o;
    dat_d         = wb_dat_o;
    sel_d         = wb_sel_o;
    rsp_valid_d   = 1'b0;
    rsp_dat_d     = rsp_dat;
    rsp_err_d     = rsp_err;
    rsp_timeout_d = rsp_timeout;

    case (state_q)
      S_IDLE: begin
        ready_d = 1'b1;
        if (req_valid && req_ready) begin
          ready_d = 1'b0;
          we_d    = req_we;
          adr_d   = req_adr;
          dat_d   = req_dat;
          sel_d   = req_sel;
          cyc_d   = 1'b1;
          stb_d   = 1'b1;
          cnt_d   = '0;
          state_d = S_REQ;
        end
      end

      S_REQ, S_WAIT: begin
        if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
        // A completion on the timeout edge still wins; err wins over ack.
        if (bus_done) begin
          state_d       = S_RESP;
          cyc_d         = 1'b0;
          stb_d         = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_err_d     = wb_err_i;
          rsp_timeout_d = 1'b0;
          rsp_dat_d     = (wb_err_i || wb_we_o) ? '0 : wb_dat_i;
        end else if (timeout_hit) begin
          state_d       = S_RESP;
          cyc_d         = 1'b0;
          stb_d         = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
          rsp_dat_d     = '0;
        end else if (strobe_taken) begin
          state_d = S_WAIT;
          stb_d   = 1'b0;
        end
      end

      S_RESP: begin
        state_d = S_IDLE;
        ready_d = 1'b1;
      end

      default: begin
        state_d = S_IDLE;
        cyc_d   = 1'b0;
        stb_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      req_ready   <= 1'b0;
      wb_cyc_o    <= 1'b0;
      wb_stb_o    <= 1'b0;
      wb_we_o     <= 1'b0;
      wb_adr_o    <= '0;
      wb_dat_o    <= '0;
      wb_sel_o    <= '0;
      rsp_valid   <= 1'b0;
      rsp_dat     <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_ready   <= ready_d;
      wb_cyc_o    <= cyc_d;
      wb_stb_o    <= stb_d;
      wb_we_o     <= we_d;
      wb_adr_o    <= adr_d;
      wb_dat_o    <= dat_d;
      wb_sel_o    <= sel_d;
      rsp_valid   <= rsp_valid_d;
      rsp_dat     <= rsp_dat_d;
      rsp_err     <= rsp_err_d;
      rsp_timeout <= rsp_timeout_d;
    end
  end

endmodule

// File: tb/tb_debug_master_wb.sv
// Bench for debug_master_wb: a transaction-window model predicts every bus/response
// cycle from the accept cycle and the responder script; directed commands drive it.
`timescale 1ns/1ps
module tb_debug_master_wb;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int SW  = DW / 8;
  localparam int TMO = 8;

  localparam int K_ACK  = 0;
  localparam int K_ERR  = 1;
  localparam int K_BOTH = 2;
  localparam int K_NONE = 3;

  logic          wb_clk_i   = 1'b0;
  logic          wb_rst_i   = 1'b1;
  logic          req_valid  = 1'b0;
  logic          req_we     = 1'b0;
  logic [AW-1:0] req_adr    = '0;
  logic [DW-1:0] req_dat    = '0;
  logic [SW-1:0] req_sel    = '0;
  logic          wb_stall_i = 1'b0;
  logic          wb_ack_i   = 1'b0;
  logic          wb_err_i   = 1'b0;
  logic [DW-1:0] wb_dat_i   = '0;

  logic          req_ready, rsp_valid, rsp_err, rsp_timeout;
  logic [DW-1:0] rsp_dat;
  logic          wb_cyc_o, wb_stb_o, wb_we_o;
  logic [AW-1:0] wb_adr_o;
  logic [DW-1:0] wb_dat_o;
  logic [SW-1:0] wb_sel_o;

  debug_master_wb #(
    .ADDR_W(AW),
    .DATA_W(DW),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .wb_clk_i(wb_clk_i),
    .wb_rst_i(wb_rst_i),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we(req_we),
    .req_adr(req_adr),
    .req_dat(req_dat),
    .req_sel(req_sel),
    .rsp_valid(rsp_valid),
    .rsp_dat(rsp_dat),
    .rsp_err(rsp_err),
    .rsp_timeout(rsp_timeout),
    .wb_cyc_o(wb_cyc_o),
    .wb_stb_o(wb_stb_o),
    .wb_we_o(wb_we_o),
    .wb_adr_o(wb_adr_o),
    .wb_dat_o(wb_dat_o),
    .wb_sel_o(wb_sel_o),
    .wb_stall_i(wb_stall_i),
    .wb_ack_i(wb_ack_i),
    .wb_dat_i(wb_dat_i),
    .wb_err_i(wb_err_i)
  );

  initial forever #5 wb_clk_i = ~wb_clk_i;

  int cycle = 0;
  initial forever begin
    @(posedge wb_clk_i);
    cycle++;
  end

  int n_compared   = 0;
  int n_mismatched = 0;

  // Plan of the command in flight, as predicted by the model.
  bit            p_active = 1'b0;
  int            p_A, p_S, p_D, p_E, p_kind;
  logic          p_we;
  logic [AW-1:0] p_adr;
  logic [DW-1:0] p_dat, p_rdata, e_dat;
  logic [SW-1:0] p_sel;
  logic          e_err, e_tmo;
  bit            rst_seen  = 1'b1;
  int            acc_count = 0;

  int            pend_S = 0, pend_D = 1, pend_kind = K_ACK;
  logic [DW-1:0] pend_rdata = '0;
  bit            stray_ack  = 1'b0;

  int            obs_stb = 0, obs_cyc = 0, obs_rv = 0, obs_rv_cycle = 0;
  logic [DW-1:0] obs_dat = '0;
  logic          obs_err = 1'b0, obs_tmo = 1'b0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Command accepted on edge A: stb spans cycles A..A+S, the responder answers D cycles
  // after its strobe is taken, and whichever of completion/timeout comes first ends it.
  initial begin : model_compare
    int   n, c;
    logic exp_cyc, exp_stb, exp_rv, exp_ready;
    forever begin
      @(negedge wb_clk_i);
      if (!wb_rst_i) begin
        p_active = 1'b0;
        rst_seen = 1'b1;
      end else begin
        n         = cycle;
        exp_cyc   = p_active && (n >= p_A) && (n < p_E);
        exp_stb   = exp_cyc && (n <= p_A + p_S);
        exp_rv    = p_active && (n == p_E);
        exp_ready = !p_active && !rst_seen;

        checkOutput("wb_cyc_o", 64'(wb_cyc_o), 64'(exp_cyc));
        checkOutput("wb_stb_o", 64'(wb_stb_o), 64'(exp_stb));
        checkOutput("rsp_valid", 64'(rsp_valid), 64'(exp_rv));
        checkOutput("req_ready", 64'(req_ready), 64'(exp_ready));
        if (exp_stb) begin
          checkOutput("wb_we_o", 64'(wb_we_o), 64'(p_we));
          checkOutput("wb_adr_o", 64'(wb_adr_o), 64'(p_adr));
          checkOutput("wb_dat_o", 64'(wb_dat_o), 64'(p_dat));
          checkOutput("wb_sel_o", 64'(wb_sel_o), 64'(p_sel));
        end
        if (exp_rv) begin
          checkOutput("rsp_dat", 64'(rsp_dat), 64'(e_dat));
          checkOutput("rsp_err", 64'(rsp_err), 64'(e_err));
          checkOutput("rsp_timeout", 64'(rsp_timeout), 64'(e_tmo));
        end

        if (wb_stb_o) obs_stb++;
        if (wb_cyc_o) obs_cyc++;
        if (rsp_valid) begin
          obs_rv++;
          obs_rv_cycle = n;
          obs_dat      = rsp_dat;
          obs_err      = rsp_err;
          obs_tmo      = rsp_timeout;
        end

        if (p_active && n >= p_E) p_active = 1'b0;
        rst_seen = 1'b0;

        if (req_valid && exp_ready) begin
          p_active = 1'b1;
          p_A      = n + 1;
          p_S      = pend_S;
          p_D      = pend_D;
          p_kind   = pend_kind;
          p_rdata  = pend_rdata;
          p_we     = req_we;
          p_adr    = req_adr;
          p_dat    = req_dat;
          p_sel    = req_sel;
          c = (pend_kind == K_NONE) ? p_A + 100000 : p_A + p_S + p_D + 1;
          if (c <= p_A + TMO) begin
            p_E   = c;
            e_err = (pend_kind == K_ERR) || (pend_kind == K_BOTH);
            e_tmo = 1'b0;
            e_dat = (e_err || req_we) ? '0 : pend_rdata;
          end else begin
            p_E   = p_A + TMO;
            e_err = 1'b1;
            e_tmo = 1'b1;
            e_dat = '0;
          end
          acc_count++;
        end
      end
    end
  end

  initial begin : responder
    int k;
    bit hit;
    forever begin
      @(posedge wb_clk_i);
      #2;
      k          = cycle;
      hit        = p_active && (p_kind != K_NONE) && (k == p_A + p_S + p_D);
      wb_stall_i = p_active && (k >= p_A) && (k < p_A + p_S);
      wb_ack_i   = (hit && (p_kind == K_ACK || p_kind == K_BOTH)) || stray_ack;
      wb_err_i   = hit && (p_kind == K_ERR || p_kind == K_BOTH);
      wb_dat_i   = hit ? p_rdata : 32'hA5A5_5A5A;
    end
  end

  task automatic applyStimulus(input logic we, input logic [AW-1:0] adr, input logic [DW-1:0] dat,
                               input logic [SW-1:0] sel, input int s, input int d, input int kind,
                               input logic [DW-1:0] rdata, input bit hold, output int present);
    int start_acc;
    pend_S     = s;
    pend_D     = d;
    pend_kind  = kind;
    pend_rdata = rdata;
    req_we     = we;
    req_adr    = adr;
    req_dat    = dat;
    req_sel    = sel;
    req_valid  = 1'b1;
    present    = cycle;
    start_acc  = acc_count;
    for (int i = 0; i < 20 && acc_count == start_acc; i++) begin
      @(posedge wb_clk_i);
      #1;
    end
    checkOutput("accept_wait", 64'(acc_count != start_acc), 64'd1);
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic waitIdle(input int budget);
    int i;
    i = 0;
    while (p_active && i < budget) begin
      @(posedge wb_clk_i);
      #1;
      i++;
    end
    checkOutput("idle_wait", 64'(!p_active), 64'd1);
  endtask

  task automatic idleCycles(input int n);
    repeat (n) begin
      @(posedge wb_clk_i);
      #1;
    end
  endtask

  initial begin : stimulus
    int pres, pres2, base_stb, base_cyc, base_rv;
    #1 wb_rst_i = 1'b0;
    idleCycles(2);
    checkOutput("rst_req_ready", 64'(req_ready), 64'd0);
    checkOutput("rst_cyc", 64'(wb_cyc_o), 64'd0);
    checkOutput("rst_stb", 64'(wb_stb_o), 64'd0);
    checkOutput("rst_we", 64'(wb_we_o), 64'd0);
    checkOutput("rst_adr", 64'(wb_adr_o), 64'd0);
    checkOutput("rst_dat_o", 64'(wb_dat_o), 64'd0);
    checkOutput("rst_sel", 64'(wb_sel_o), 64'd0);
    checkOutput("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    checkOutput("rst_rsp_dat", 64'(rsp_dat), 64'd0);
    checkOutput("rst_rsp_err", 64'(rsp_err), 64'd0);
    checkOutput("rst_rsp_timeout", 64'(rsp_timeout), 64'd0);
    wb_rst_i = 1'b1;
    idleCycles(2);
    checkOutput("ready_after_reset", 64'(req_ready), 64'd1);

    // Write, no stall, ack one cycle after stb.
    base_stb = obs_stb;
    applyStimulus(1'b1, 32'h8000_0000, 32'h1, 4'hF, 0, 1, K_ACK, 32'hFFFF_0000, 1'b0, pres);
    waitIdle(30);
    checkOutput("wr_stb_cycles", 64'(obs_stb - base_stb), 64'd1);
    checkOutput("wr_latency", 64'(obs_rv_cycle - pres), 64'd3);
    checkOutput("wr_rsp_err", 64'(obs_err), 64'd0);
    checkOutput("wr_rsp_dat", 64'(obs_dat), 64'd0);

    // Read held off by three stall cycles.
    base_stb = obs_stb;
    applyStimulus(1'b0, 32'h0000_1004, 32'h0, 4'h3, 3, 1, K_ACK, 32'hDEAD_BEEF, 1'b0, pres);
    waitIdle(30);
    checkOutput("rd_stall_stb_cycles", 64'(obs_stb - base_stb), 64'd4);
    checkOutput("rd_stall_dat", 64'(obs_dat), 64'hDEAD_BEEF);
    checkOutput("rd_stall_err", 64'(obs_err), 64'd0);

    // ack and err together: err wins, data forced to zero.
    applyStimulus(1'b0, 32'h0000_2000, 32'h0, 4'hF, 0, 1, K_BOTH, 32'h1234_5678, 1'b0, pres);
    waitIdle(30);
    checkOutput("both_err", 64'(obs_err), 64'd1);
    checkOutput("both_tmo", 64'(obs_tmo), 64'd0);
    checkOutput("both_dat", 64'(obs_dat), 64'd0);

    applyStimulus(1'b0, 32'h0000_2004, 32'h0, 4'hF, 0, 1, K_ACK, 32'h0000_0042, 1'b0, pres);
    waitIdle(30);
    checkOutput("after_err_err", 64'(obs_err), 64'd0);
    checkOutput("after_err_dat", 64'(obs_dat), 64'h42);

    // err on the same edge the strobe is taken: straight to the response.
    applyStimulus(1'b0, 32'h0000_3000, 32'h0, 4'h1, 0, 0, K_ERR, 32'h5555_5555, 1'b0, pres);
    waitIdle(30);
    checkOutput("err_d0_latency", 64'(obs_rv_cycle - pres), 64'd2);
    checkOutput("err_d0_err", 64'(obs_err), 64'd1);

    // No answer at all: timeout after TMO cycles of cyc.
    base_cyc = obs_cyc;
    applyStimulus(1'b0, 32'h0000_4000, 32'h0, 4'hF, 0, 0, K_NONE, 32'h0, 1'b0, pres);
    waitIdle(40);
    checkOutput("tmo_cyc_cycles", 64'(obs_cyc - base_cyc), 64'd8);
    checkOutput("tmo_err", 64'(obs_err), 64'd1);
    checkOutput("tmo_flag", 64'(obs_tmo), 64'd1);
    checkOutput("tmo_dat", 64'(obs_dat), 64'd0);

    base_rv   = obs_rv;
    stray_ack = 1'b1;
    idleCycles(2);
    stray_ack = 1'b0;
    idleCycles(3);
    checkOutput("stray_ack_no_rsp", 64'(obs_rv - base_rv), 64'd0);

    // Completion on the timeout edge beats the timeout; one cycle later it does not.
    applyStimulus(1'b0, 32'h0000_5000, 32'h0, 4'hF, 0, TMO - 1, K_ACK, 32'h0000_0777, 1'b0, pres);
    waitIdle(40);
    checkOutput("edge_ack_tmo", 64'(obs_tmo), 64'd0);
    checkOutput("edge_ack_dat", 64'(obs_dat), 64'h777);
    applyStimulus(1'b0, 32'h0000_5004, 32'h0, 4'hF, 0, TMO, K_ACK, 32'h0000_0888, 1'b0, pres);
    waitIdle(40);
    checkOutput("late_ack_tmo", 64'(obs_tmo), 64'd1);
    checkOutput("late_ack_err", 64'(obs_err), 64'd1);

    // Back-to-back writes with req_valid held high.
    base_rv = obs_rv;
    applyStimulus(1'b1, 32'h0000_0010, 32'h1, 4'hF, 0, 1, K_ACK, 32'h0, 1'b1, pres);
    applyStimulus(1'b1, 32'h0000_0014, 32'h1F, 4'hF, 0, 1, K_ACK, 32'h0, 1'b0, pres2);
    waitIdle(30);
    checkOutput("b2b_rsp_count", 64'(obs_rv - base_rv), 64'd2);
    checkOutput("b2b_second_rsp_cycle", 64'(obs_rv_cycle - pres), 64'd7);

    // Reset while waiting for the ack.
    base_rv = obs_rv;
    applyStimulus(1'b0, 32'h0000_6000, 32'h0, 4'hF, 0, 5, K_ACK, 32'hCAFE_F00D, 1'b0, pres);
    @(posedge wb_clk_i);
    #3;
    checkOutput("pre_rst_cyc", 64'(wb_cyc_o), 64'd1);
    checkOutput("pre_rst_stb", 64'(wb_stb_o), 64'd0);
    wb_rst_i = 1'b0;
    #1;
    checkOutput("async_rst_cyc", 64'(wb_cyc_o), 64'd0);
    checkOutput("async_rst_stb", 64'(wb_stb_o), 64'd0);
    checkOutput("async_rst_rsp_valid", 64'(rsp_valid), 64'd0);
    checkOutput("async_rst_ready", 64'(req_ready), 64'd0);
    idleCycles(1);
    wb_rst_i = 1'b1;
    idleCycles(10);
    checkOutput("rst_abort_no_rsp", 64'(obs_rv - base_rv), 64'd0);
    checkOutput("rst_abort_ready", 64'(req_ready), 64'd1);

    applyStimulus(1'b0, 32'h0000_7000, 32'h0, 4'hC, 1, 2, K_ACK, 32'h0BAD_C0DE, 1'b0, pres);
    waitIdle(30);
    checkOutput("post_rst_rd_dat", 64'(obs_dat), 64'h0BAD_C0DE);
    idleCycles(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got cycle %0d, expected under 20000", cycle);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
